// File: rtl/audio_clkgen.sv
// Codec clock generator: holds the codec in power-down, then derives bclk/lrck/TDM
// slot timing from a free-running frame counter and flags ready after settling.
module audio_clkgen #(
  parameter int unsigned PDN_CYCLES    = 1024,
  parameter int unsigned SETTLE_FRAMES = 16
) (
  input  logic       clk_12m,
  input  logic       rst_in,
  input  logic       resync_req,
  output logic       pdn_n,
  output logic       bclk,
  output logic       lrck,
  output logic       frame_strobe,
  output logic [1:0] slot,
  output logic [4:0] bit_idx,
  output logic       ready
);

  localparam int unsigned PW = 16;
  localparam int unsigned FW = 8;
  localparam logic [PW-1:0] PDN_LAST    = PW'(PDN_CYCLES - 1);
  localparam logic [FW-1:0] SETTLE_LAST = FW'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {HOLD, SETTLE, RUN} state_t;

  state_t        state, state_d;
  logic [PW-1:0] pdn_cnt, pdn_cnt_d;
  logic [FW-1:0] set_cnt, set_cnt_d;
  logic [FW-1:0] fcnt, fcnt_d;

  logic       active_d;
  logic       pdn_n_d, bclk_d, lrck_d, frame_strobe_d, ready_d;
  logic [1:0] slot_d;
  logic [4:0] bit_idx_d;

  // State, counters and every output pin are flops.
  always_ff @(posedge clk_12m or posedge rst_in) begin
    if (rst_in) begin
      state        <= HOLD;
      pdn_cnt      <= '0;
      set_cnt      <= '0;
      fcnt         <= '0;
      pdn_n        <= 1'b0;
      bclk         <= 1'b0;
      lrck         <= 1'b0;
      frame_strobe <= 1'b0;
      slot         <= '0;
      bit_idx      <= '0;
      ready        <= 1'b0;
    end else begin
      state        <= state_d;
      pdn_cnt      <= pdn_cnt_d;
      set_cnt      <= set_cnt_d;
      fcnt         <= fcnt_d;
      pdn_n        <= pdn_n_d;
      bclk         <= bclk_d;
      lrck         <= lrck_d;
      frame_strobe <= frame_strobe_d;
      slot         <= slot_d;
      bit_idx      <= bit_idx_d;
      ready        <= ready_d;
    end
  end

  // Next state and counters; output pins are decoded from next-cycle fcnt so they can be registered.
  always_comb begin
    state_d   = state;
    pdn_cnt_d = pdn_cnt;
    set_cnt_d = set_cnt;
    fcnt_d    = fcnt;

    case (state)
      HOLD: begin
        fcnt_d = '0;
        if (pdn_cnt == PDN_LAST) begin
          state_d   = SETTLE;
          pdn_cnt_d = '0;
        end else begin
          pdn_cnt_d = pdn_cnt + PW'(1);
        end
      end
      SETTLE: begin
        fcnt_d = fcnt + FW'(1);
        if (fcnt == '1) begin
          if (set_cnt == SETTLE_LAST) begin
            state_d   = RUN;
            set_cnt_d = '0;
          end else begin
            set_cnt_d = set_cnt + FW'(1);
          end
        end
      end
      RUN: begin
        fcnt_d = fcnt + FW'(1);
      end
      default: begin
        state_d = HOLD;
        fcnt_d  = '0;
      end
    endcase

    // Resync overrides any transition taken above.
    if (resync_req) begin
      state_d   = HOLD;
      pdn_cnt_d = '0;
      set_cnt_d = '0;
      fcnt_d    = '0;
    end

    active_d       = (state_d != HOLD);
    pdn_n_d        = active_d;
    ready_d        = (state_d == RUN);
    bclk_d         = active_d & fcnt_d[0];
    lrck_d         = active_d & ~fcnt_d[7];
    frame_strobe_d = active_d & (fcnt_d == '0);
    slot_d         = active_d ? fcnt_d[7:6] : 2'd0;
    bit_idx_d      = active_d ? ~fcnt_d[5:1] : 5'd0;
  end

endmodule

// File: tb/tb_audio_clkgen.sv
// Bench for audio_clkgen: directed power-up/resync/reset scenarios plus random resync
// traffic, all compared each cycle against a time-since-restart reference model.
module tb_audio_clkgen;

  localparam int unsigned P = 16;
  localparam int unsigned S = 2;
  localparam int READY_K = P + 256 * S;

  logic       clk_12m = 1'b0;
  logic       rst_in;
  logic       resync_req;
  logic       pdn_n, bclk, lrck, frame_strobe, ready;
  logic [1:0] slot;
  logic [4:0] bit_idx;

  int n_cmp  = 0;
  int n_fail = 0;
  int k      = 0;

  audio_clkgen #(.PDN_CYCLES(P), .SETTLE_FRAMES(S)) dut (
    .clk_12m     (clk_12m),
    .rst_in      (rst_in),
    .resync_req  (resync_req),
    .pdn_n       (pdn_n),
    .bclk        (bclk),
    .lrck        (lrck),
    .frame_strobe(frame_strobe),
    .slot        (slot),
    .bit_idx     (bit_idx),
    .ready       (ready)
  );

  always #5 clk_12m = ~clk_12m;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Expected pins k cycles after the sequence (re)started; k=0 is the first held cycle.
  function automatic logic [31:0] model(input int kk);
    int n, sl, bi;
    logic rdy;
    if (kk < int'(P)) return 32'd0;
    n   = (kk - int'(P)) % 256;
    rdy = (kk >= READY_K);
    sl  = n / 64;
    bi  = 31 - ((n % 64) / 2);
    return {20'd0, 1'b1, rdy, 1'(n % 2), 1'(n < 128), 1'(n == 0), 2'(sl), 5'(bi)};
  endfunction

  function automatic logic [31:0] pins();
    return {20'd0, pdn_n, ready, bclk, lrck, frame_strobe, slot, bit_idx};
  endfunction

  // One clock with resync_req = rq; model advances on the edge, compare at the falling edge.
  task automatic tick(input logic rq);
    resync_req = rq;
    @(posedge clk_12m);
    if (rst_in || rq) k = 0;
    else k++;
    @(negedge clk_12m);
    check("pins", pins(), model(k));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // Count further low pdn_n cycles after the current sample, bounded.
  task automatic count_low(input string tag, input int exp);
    int lows;
    lows = 0;
    for (int i = 0; i < 3 * int'(P) && pdn_n == 1'b0; i++) begin
      tick(1'b0);
      if (pdn_n == 1'b0) lows++;
    end
    check(tag, 32'(lows), 32'(exp));
  endtask

  initial begin
    rst_in     = 1'b1;
    resync_req = 1'b0;
    repeat (3) @(posedge clk_12m);
    @(negedge clk_12m);
    check("reset_state", pins(), 32'd0);
    rst_in = 1'b0;

    // Power-up timing from reset release.
    for (int i = 0; i < 600; i++) begin
      tick(1'b0);
      if (k == 15) check("pdn_c15", 32'(pdn_n), 32'd0);
      if (k == 16) check("pdn_strobe_c16", 32'({pdn_n, frame_strobe}), 32'd3);
      if (k == 527) check("ready_c527", 32'(ready), 32'd0);
      if (k == 528) check("ready_strobe_c528", 32'({ready, frame_strobe}), 32'd3);
      if (k == READY_K + 65) check("slot_bit_n65", 32'({slot, bit_idx}), 32'({2'd1, 5'd31}));
      if (k == READY_K + 255) check("slot_bit_n255", 32'({slot, bit_idx}), 32'({2'd3, 5'd0}));
    end

    // One-cycle resync at fcnt=77 in RUN.
    for (int i = 0; i < 300 && (k - int'(P)) % 256 != 76; i++) tick(1'b0);
    tick(1'b0);
    check("at_n77", 32'({ready, slot, bit_idx}), 32'({1'b1, 2'd1, 5'd31 - 5'd6}));
    tick(1'b1);
    check("resync_levels", 32'({pdn_n, ready, bclk, lrck}), 32'd0);
    run(600);

    // Asynchronous reset between edges during RUN.
    @(posedge clk_12m);
    k++;
    #2 rst_in = 1'b1;
    k = 0;
    #1 check("async_reset", pins(), 32'd0);
    @(posedge clk_12m);
    @(negedge clk_12m);
    check("reset_hold", pins(), 32'd0);
    rst_in = 1'b0;
    run(560);

    // resync held 40 cycles, then released.
    for (int i = 0; i < 40; i++) tick(1'b1);
    count_low("hold_release_lows", int'(P) - 1);

    // One-cycle resync on the last HOLD count cycle.
    tick(1'b1);
    run(int'(P) - 1);
    check("last_hold_k", 32'(pdn_n), 32'd0);
    tick(1'b1);
    count_low("last_hold_lows", int'(P) - 1);

    // resync on the SETTLE->RUN wrap cycle.
    for (int i = 0; i < 700 && k != READY_K - 1; i++) tick(1'b0);
    tick(1'b1);
    check("race_ready", 32'({ready, pdn_n}), 32'd0);
    run(600);

    // Random resync traffic.
    for (int it = 0; it < 16; it++) begin
      int gap, len;
      gap = int'($urandom_range(1, 700));
      len = int'($urandom_range(1, 3));
      run(gap);
      for (int j = 0; j < len; j++) tick(1'b1);
    end
    run(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
